trdb_apb_regs: RTL and testbench

- APB3 responder exposing the trace encoder's control and status registers to software.
- Owns the trace enable state machine, driven by:
  - software writes;
  - on requests from the trigger unit;
  - off requests from the filter.
- Sequences an orderly stop: enable drops, the block requests a flush, and it waits for the encoder's flush acknowledge.
- Drives the configuration lines consumed by the packet emitter.

---
 rtl/trdb_apb_regs.sv | 108 ++++++++++
 tb/tb_trdb_apb_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_apb_regs.sv
// trdb_apb_regs: APB3 control/status registers and trace enable state machine for the trace encoder.
// Ports:
//   clk_i, rst_ni                           clock, asynchronous active-low reset
//   psel_i, penable_i, pwrite_i, paddr_i,
//   pwdata_i, prdata_o, pready_o, pslverr_o APB3 responder, zero wait states
//   trace_req_on_i, trace_req_off_i         start/stop request pulses (trigger unit / filter)
//   flush_ack_i, flush_req_o                drain handshake with the encoder during an orderly stop
//   trace_enable_o, trace_activated_o       tracing running / armed by software
//   nocontext_o, notime_o, encoder_mode_o,
//   delta_address_o, full_address_o         configuration lines for the packet emitter
module trdb_apb_regs #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              trace_req_on_i,
    input  logic              trace_req_off_i,
    input  logic              flush_ack_i,
    output logic              trace_enable_o,
    output logic              trace_activated_o,
    output logic              flush_req_o,
    output logic              nocontext_o,
    output logic              notime_o,
    output logic              encoder_mode_o,
    output logic              delta_address_o,
    output logic              full_address_o
);
    typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, STOPPING = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             act_q, act_d, noc_q, not_q, delta_q, full_q, missed_q, en_q, flush_q;
    logic [CNT_W-1:0] cnt_q;
    logic             access, err, wr_ok, wr_ctrl, wr_clr, start, stop, go_on, miss;
    logic [2:0]       idx;
    logic             unused;

    assign access  = psel_i & penable_i;
    assign idx     = paddr_i[4:2];
    assign err     = access & ((paddr_i[1:0] != 2'b00) | idx[2] | (pwrite_i & (idx == 3'd1 | idx == 3'd2)));
    assign wr_ok   = access & pwrite_i & ~err;
    assign wr_ctrl = wr_ok & (idx == 3'd0);
    assign wr_clr  = wr_ok & (idx == 3'd3);
    assign act_d   = wr_ctrl ? pwdata_i[0] : act_q;
    assign start   = trace_req_on_i | (wr_ctrl & pwdata_i[1]);
    assign stop    = trace_req_off_i | (wr_ctrl & pwdata_i[2]);
    // Starts are judged against the activated value before this cycle's write.
    assign go_on   = (state_q == OFF) & act_q & start & ~stop;
    assign miss    = (state_q == OFF) & ~act_q & start;
    assign unused  = ^{paddr_i[ADDR_W-1:5], pwdata_i[31:7]};

    always_comb begin
        state_d = state_q;
        if (state_q == OFF && go_on)
            state_d = ON;
        else if (state_q == ON && (stop | (act_q & ~act_d)))
            state_d = STOPPING;
        else if (state_q == STOPPING && flush_ack_i)
            state_d = OFF;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= OFF;
            en_q     <= 1'b0;
            flush_q  <= 1'b0;
            act_q    <= 1'b0;
            noc_q    <= 1'b1;
            not_q    <= 1'b1;
            delta_q  <= 1'b1;
            full_q   <= 1'b0;
            missed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= state_d == ON;
            flush_q  <= state_d == STOPPING;
            act_q    <= act_d;
            if (wr_ctrl) {full_q, delta_q, not_q, noc_q} <= pwdata_i[6:3];
            // A new miss overrides a simultaneous clear; a clear overrides a simultaneous increment.
            missed_q <= (missed_q & ~(wr_clr & pwdata_i[0])) | miss;
            cnt_q    <= (wr_clr & pwdata_i[1]) ? '0 : cnt_q + CNT_W'(go_on);
        end
    end

    assign prdata_o = ~access      ? 32'b0 :
                      idx == 3'd0  ? {25'b0, full_q, delta_q, not_q, noc_q, 2'b00, act_q} :
                      idx == 3'd1  ? {22'b0, state_q, 5'b0, missed_q, state_q == STOPPING, en_q} :
                      idx == 3'd2  ? 32'(cnt_q) : 32'b0;
    assign pready_o          = access;
    assign pslverr_o         = err;
    assign trace_enable_o    = en_q;
    assign flush_req_o       = flush_q;
    assign trace_activated_o = act_q;
    assign nocontext_o       = noc_q;
    assign notime_o          = not_q;
    assign delta_address_o   = delta_q;
    assign full_address_o    = full_q;
    assign encoder_mode_o    = 1'b0;
endmodule

// File: tb/tb_trdb_apb_regs.sv
// tb_trdb_apb_regs: self-checking bench for trdb_apb_regs against a behavioural register/enable model.
module tb_trdb_apb_regs;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0, prdata;
    logic        pready, pslverr;
    logic        on = 1'b0, off = 1'b0, ack = 1'b0;
    logic        trace_enable_o, trace_activated_o, flush_req_o, nocontext_o, notime_o;
    logic        encoder_mode_o, delta_address_o, full_address_o;
    int          checks = 0, errors = 0;
    int          m_mode, m_cnt;
    bit          m_act, m_noc, m_not, m_dlt, m_full, m_miss;

    trdb_apb_regs #(.ADDR_W(12), .CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .trace_req_on_i(on), .trace_req_off_i(off), .flush_ack_i(ack),
        .trace_enable_o(trace_enable_o), .trace_activated_o(trace_activated_o), .flush_req_o(flush_req_o),
        .nocontext_o(nocontext_o), .notime_o(notime_o), .encoder_mode_o(encoder_mode_o),
        .delta_address_o(delta_address_o), .full_address_o(full_address_o)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_cnt = 0; m_act = 0; m_noc = 1; m_not = 1; m_dlt = 1; m_full = 0; m_miss = 0;
    endfunction

    function automatic bit model_err(bit wr, logic [11:0] a);
        int w = int'(a[4:2]);
        return a[1:0] != 2'b00 || w > 3 || (wr && (w == 1 || w == 2));
    endfunction

    function automatic logic [31:0] exp_read(logic [11:0] a);
        int w = int'(a[4:2]);
        if (w == 0) return 32'(m_act) | 32'(m_noc) << 3 | 32'(m_not) << 4 | 32'(m_dlt) << 5 | 32'(m_full) << 6;
        if (w == 1) return 32'(m_mode) << 8 | 32'(m_miss) << 2 | 32'(m_mode == 2) << 1 | 32'(m_mode == 1);
        if (w == 2) return 32'(m_cnt);
        return 32'h0;
    endfunction

    // One clock edge of the reference model: requests, a possible register write, and the enable rules.
    function automatic void model_step(bit on_, bit off_, bit ack_, bit wr, logic [11:0] a, logic [31:0] d);
        int  w = int'(a[4:2]);
        bit  ok = wr && !model_err(wr, a);
        bit  wc = ok && w == 0, wcl = ok && w == 3;
        bit  start = on_ || (wc && d[1]), stop = off_ || (wc && d[2]), old = m_act;
        int  inc = 0;
        if (wc) begin m_act = d[0]; m_noc = d[3]; m_not = d[4]; m_dlt = d[5]; m_full = d[6]; end
        if (wcl && d[0]) m_miss = 0;
        if (m_mode == 0) begin
            if (start && !old) m_miss = 1;
            else if (start && !stop) begin m_mode = 1; inc = 1; end
        end else if (m_mode == 1) begin
            if (stop || (old && !m_act)) m_mode = 2;
        end else if (ack_) m_mode = 0;
        m_cnt = (m_cnt + inc) % 16;
        if (wcl && d[1]) m_cnt = 0;
    endfunction

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output logic rdy);
        @(negedge clk); psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1 model_step(on, off, ack, 0, a, d);
        @(negedge clk); penable = 1;
        #1 rd = prdata; er = pslverr; rdy = pready;
        @(posedge clk); #1 model_step(on, off, ack, wr, a, d);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic pulse(input bit o1, input bit o2, input bit a1);
        @(negedge clk); on = o1; off = o2; ack = a1;
        @(posedge clk); #1 model_step(on, off, ack, 0, 12'h0, 32'h0);
        on = 0; off = 0; ack = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, rdy;
        logic [41:0] got, exp;
        rst_n = 0; model_reset();
        repeat (2) @(posedge clk);
        #1 got = {trace_enable_o, trace_activated_o, flush_req_o, nocontext_o, notime_o, encoder_mode_o,
                  delta_address_o, full_address_o, pslverr, pready, prdata};
        exp = {8'b00011010, 2'b00, 32'h0};
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
        @(negedge clk); rst_n = 1;
        apb(0, 12'h0, 0, rd, er, rdy);
        checks++; if (rd !== 32'h38 || er !== 0) begin errors++; $display("FAIL reset_ctrl: got %h/%b want 38/0", rd, er); end
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
        apb(0, 12'h8, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_evcnt: got %h want 0", rd); end
    endtask

    task automatic test_start_stop();
        logic [31:0] rd; logic er, rdy;
        apb(1, 12'h0, 32'h39, rd, er, rdy);
        checks++; if (trace_activated_o !== 1 || er !== 0) begin errors++; $display("FAIL arm: act %b err %b want 1/0", trace_activated_o, er); end
        pulse(1, 0, 0);
        checks++; if (trace_enable_o !== 1 || flush_req_o !== 0) begin errors++; $display("FAIL start: en %b fl %b want 1/0", trace_enable_o, flush_req_o); end
        apb(0, 12'h8, 0, rd, er, rdy);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL evcnt_after_start: got %h want 1", rd); end
        pulse(0, 1, 0);
        checks++; if (trace_enable_o !== 0 || flush_req_o !== 1) begin errors++; $display("FAIL stop: en %b fl %b want 0/1", trace_enable_o, flush_req_o); end
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h202) begin errors++; $display("FAIL status_stopping: got %h want 202", rd); end
        pulse(0, 0, 1);
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0 || flush_req_o !== 0) begin errors++; $display("FAIL status_off: got %h fl %b want 0/0", rd, flush_req_o); end
    endtask

    task automatic test_missed();
        logic [31:0] rd; logic er, rdy;
        apb(1, 12'h0, 32'h38, rd, er, rdy);
        pulse(1, 0, 0);
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h4 || trace_enable_o !== 0) begin errors++; $display("FAIL missed_set: got %h en %b want 4/0", rd, trace_enable_o); end
        apb(1, 12'hC, 32'h1, rd, er, rdy);
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL missed_clear: got %h want 0", rd); end
        on = 1;
        apb(1, 12'hC, 32'h1, rd, er, rdy);
        on = 0;
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h4 || rd !== exp_read(12'h4)) begin errors++; $display("FAIL miss_beats_clear: got %h want 4", rd); end
        apb(1, 12'hC, 32'h1, rd, er, rdy);
        on = 1;
        apb(1, 12'h0, 32'h39, rd, er, rdy);
        on = 0;
        checks++; if (trace_enable_o !== 0 || m_mode != 0) begin errors++; $display("FAIL start_with_arm: en %b want 0", trace_enable_o); end
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL start_with_arm_missed: got %h want 4", rd); end
        apb(1, 12'hC, 32'h1, rd, er, rdy);
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd; logic er, rdy; int c0;
        apb(1, 12'h0, 32'h39, rd, er, rdy);
        c0 = m_cnt;
        pulse(1, 1, 0);
        apb(0, 12'h8, 0, rd, er, rdy);
        checks++; if (trace_enable_o !== 0 || rd !== 32'(c0)) begin errors++; $display("FAIL onoff_in_off: en %b cnt %h want 0/%h", trace_enable_o, rd, c0); end
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h202 || flush_req_o !== 1) begin errors++; $display("FAIL onoff_in_on: got %h fl %b want 202/1", rd, flush_req_o); end
        pulse(1, 0, 0);
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h202) begin errors++; $display("FAIL on_in_stopping: got %h want 202", rd); end
        pulse(0, 0, 1);
        apb(1, 12'h0, 32'h3B, rd, er, rdy);
        checks++; if (trace_enable_o !== 1) begin errors++; $display("FAIL sw_start: en %b want 1", trace_enable_o); end
        apb(0, 12'h0, 0, rd, er, rdy);
        checks++; if (rd !== 32'h39) begin errors++; $display("FAIL sw_bits_read0: got %h want 39", rd); end
        apb(1, 12'h0, 32'h38, rd, er, rdy);
        checks++; if (flush_req_o !== 1 || trace_enable_o !== 0) begin errors++; $display("FAIL deactivate_stops: fl %b en %b want 1/0", flush_req_o, trace_enable_o); end
        pulse(0, 0, 1);
    endtask

    task automatic test_bus_errors();
        logic [31:0] rd; logic er, rdy, c0, s0;
        logic [11:0] ad[5] = '{12'h4, 12'h2, 12'h10, 12'h2, 12'h8};
        bit          wr[5] = '{1, 0, 0, 1, 1};
        checks++; if (pready !== 0) begin errors++; $display("FAIL idle_pready: got %b want 0", pready); end
        for (int i = 0; i < 5; i++) begin
            apb(wr[i], ad[i], 32'h7F, rd, er, rdy);
            checks++; if (er !== 1 || rdy !== 1) begin errors++; $display("FAIL bus_err_%0d: err %b rdy %b want 1/1", i, er, rdy); end
        end
        apb(1, 12'h12, 32'h7F, rd, er, rdy);
        checks++; if (er !== 1) begin errors++; $display("FAIL bus_err_idx4: err %b want 1", er); end
        apb(0, 12'h0, 0, rd, er, rdy);
        checks++; if (rd !== 32'h38 || er !== 0) begin errors++; $display("FAIL err_no_change_ctrl: got %h/%b want 38/0", rd, er); end
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_no_change_status: got %h want 0", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er, rdy;
        apb(1, 12'hC, 32'h2, rd, er, rdy);
        apb(1, 12'h0, 32'h39, rd, er, rdy);
        for (int i = 0; i < 16; i++) begin
            pulse(1, 0, 0); pulse(0, 1, 0); pulse(0, 0, 1);
            if (i == 14) begin
                apb(0, 12'h8, 0, rd, er, rdy);
                checks++; if (rd !== 32'hF) begin errors++; $display("FAIL evcnt_15: got %h want f", rd); end
            end
        end
        apb(0, 12'h8, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL evcnt_wrap: got %h want 0", rd); end
        pulse(1, 0, 0);
        on = 0;
        apb(1, 12'hC, 32'h2, rd, er, rdy);
        apb(0, 12'h8, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL evcnt_clear: got %h want 0", rd); end
        pulse(0, 1, 0); pulse(0, 0, 1);
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic er, rdy; logic [11:0] a; int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 5);
            if (r <= 1) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            else if (r == 2) apb(1, 12'h0, ($urandom & 32'h79) | (($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1), rd, er, rdy);
            else if (r == 3) apb(1, 12'hC, $urandom & 32'h3, rd, er, rdy);
            else begin
                a = (r == 4) ? 12'(4 * $urandom_range(0, 3)) : 12'($urandom_range(0, 31));
                d = $urandom;
                apb(r == 5 && a[0], a, d, rd, er, rdy);
                if (r == 4) begin
                    checks++; if (rd !== exp_read(a)) begin errors++; $display("FAIL rand_read@%h: got %h want %h", a, rd, exp_read(a)); end
                end else begin
                    checks++; if (er !== model_err(a[0], a)) begin errors++; $display("FAIL rand_err@%h: got %b want %b", a, er, model_err(a[0], a)); end
                end
            end
            checks++;
            if ({trace_enable_o, flush_req_o, trace_activated_o, nocontext_o, notime_o, delta_address_o, full_address_o, encoder_mode_o}
                !== {m_mode == 1, m_mode == 2, m_act, m_noc, m_not, m_dlt, m_full, 1'b0}) begin
                errors++;
                $display("FAIL rand_outputs step %0d: got %b%b%b%b%b%b%b%b want mode %0d act %b cfg %b%b%b%b", i,
                         trace_enable_o, flush_req_o, trace_activated_o, nocontext_o, notime_o, delta_address_o,
                         full_address_o, encoder_mode_o, m_mode, m_act, m_noc, m_not, m_dlt, m_full);
            end
        end
    endtask

    task automatic test_reset_in_stopping();
        logic [31:0] rd; logic er, rdy;
        apb(1, 12'h0, 32'h79, rd, er, rdy);
        if (m_mode == 2) pulse(0, 0, 1);
        if (m_mode == 1) pulse(0, 1, 0);
        else begin pulse(1, 0, 0); pulse(0, 1, 0); end
        checks++; if (flush_req_o !== 1) begin errors++; $display("FAIL pre_reset_stopping: fl %b want 1", flush_req_o); end
        @(posedge clk); #3 rst_n = 0;
        #1;
        checks++; if ({flush_req_o, trace_enable_o, trace_activated_o, full_address_o, nocontext_o} !== 5'b00001) begin
            errors++; $display("FAIL async_reset: fl %b en %b act %b full %b noc %b want 0/0/0/0/1",
                                flush_req_o, trace_enable_o, trace_activated_o, full_address_o, nocontext_o);
        end
        model_reset();
        @(negedge clk); rst_n = 1;
        apb(0, 12'h4, 0, rd, er, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_after_reset: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_missed();
        test_simultaneous();
        test_bus_errors();
        test_wrap();
        test_random();
        test_reset_in_stopping();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
